// File: rtl/d2l_tx_scheduler_pkg.sv
// d2l_pkg: shared types and helpers for the D2L transmit scheduler
package d2l_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_GAP = 2'd2} d2l_state_e;
  localparam logic CS_INACTIVE = 1'b1;
  function automatic int D2L_PAIRS(input int w);
    return w / 2;
  endfunction
  function automatic int d2l_idx_w(input int n);
    return $clog2(n > 2 ? n : 2);
  endfunction
endpackage

// File: rtl/d2l_tx_scheduler_if.sv
// d2l_tx_scheduler_if: requester-side valid/ready word bus
interface d2l_tx_scheduler_if #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_REQ    = 2
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  modport master (output req_valid, output req_data, input req_ready);
  modport slave  (input req_valid, input req_data, output req_ready);
endinterface

// File: rtl/d2l_rr_arbiter.sv
// d2l_rr_arbiter: combinational round-robin pick starting after ptr
module d2l_rr_arbiter
  import d2l_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]              req,
  input  logic [d2l_idx_w(NUM_REQ)-1:0]   ptr,
  input  logic                            en,
  output logic [NUM_REQ-1:0]              gnt,
  output logic [d2l_idx_w(NUM_REQ)-1:0]   gnt_idx
);
  localparam int IW = d2l_idx_w(NUM_REQ);
  logic found;
  int   idx;
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int o = 1; o <= NUM_REQ; o++) begin
      idx = (int'(ptr) + o) % NUM_REQ;
      if (en && !found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = IW'(idx);
      end
    end
  end
endmodule

// File: rtl/d2l_tx_scheduler.sv
// d2l_tx_scheduler: round-robin shares one D2L link master, framing words
// onto CS/OutLine1/OutLine0 two bits per sclk, MSB first.
module d2l_tx_scheduler
  import d2l_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_REQ    = 2,
  parameter int GAP_CYCLES = 2
) (
  input  logic                          sclk,
  input  logic                          rstn,
  d2l_tx_scheduler_if.slave             rq,
  output logic                          CS,
  output logic                          OutLine1,
  output logic                          OutLine0,
  output logic                          busy,
  output logic [d2l_idx_w(NUM_REQ)-1:0] grant_id,
  output logic                          tx_done
);
  localparam int P  = D2L_PAIRS(DATA_WIDTH);
  localparam int KW = $clog2(P + 1);
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  localparam int IW = d2l_idx_w(NUM_REQ);

  if (DATA_WIDTH % 2 != 0 || DATA_WIDTH < 2) begin : g_bad_width
    $error("d2l_tx_scheduler: DATA_WIDTH must be even and >= 2");
  end

  d2l_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic [KW-1:0]         k_q, k_d;
  logic [GW-1:0]         g_q, g_d;
  logic [IW-1:0]         ptr_q, ptr_d, gid_q, gid_d, win;
  logic                  cs_q, cs_d, l1_q, l1_d, l0_q, l0_d, done_q, done_d, hs;

  // Arbitration is gated by rstn so req_ready stays low throughout reset.
  d2l_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req     (rq.req_valid),
    .ptr     (ptr_q),
    .en      (state_q == ST_IDLE && rstn),
    .gnt     (rq.req_ready),
    .gnt_idx (win)
  );

  assign hs = |(rq.req_valid & rq.req_ready);

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    k_d     = k_q;
    g_d     = g_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    cs_d    = cs_q;
    l1_d    = 1'b0;
    l0_d    = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: if (hs) begin
        sr_d    = rq.req_data[int'(win)*DATA_WIDTH +: DATA_WIDTH];
        cs_d    = ~CS_INACTIVE;
        k_d     = '0;
        ptr_d   = win;
        gid_d   = win;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: if (k_q == KW'(P)) begin
        cs_d    = CS_INACTIVE;
        done_d  = 1'b1;
        g_d     = '0;
        state_d = GAP_CYCLES == 0 ? ST_IDLE : ST_GAP;
      end else begin
        l1_d = sr_q[DATA_WIDTH-1];
        l0_d = sr_q[DATA_WIDTH-2];
        sr_d = sr_q << 2;
        k_d  = k_q + KW'(1);
      end
      ST_GAP: if (g_q == GW'(GAP_CYCLES - 1)) state_d = ST_IDLE;
              else g_d = g_q + GW'(1);
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      k_q     <= '0;
      g_q     <= '0;
      ptr_q   <= IW'(NUM_REQ - 1);
      gid_q   <= '0;
      cs_q    <= CS_INACTIVE;
      l1_q    <= 1'b0;
      l0_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      k_q     <= k_d;
      g_q     <= g_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      cs_q    <= cs_d;
      l1_q    <= l1_d;
      l0_q    <= l0_d;
      done_q  <= done_d;
    end
  end

  assign CS       = cs_q;
  assign OutLine1 = l1_q;
  assign OutLine0 = l0_q;
  assign busy     = state_q != ST_IDLE;
  assign grant_id = gid_q;
  assign tx_done  = done_q;
endmodule

// File: tb/tb_d2l_tx_scheduler.sv
// tb_d2l_tx_scheduler: directed scoreboard bench; a line-level receiver
// model reassembles frames and checks them against queued expectations.
module tb_d2l_tx_scheduler;
  typedef struct {logic id; logic [63:0] data;} exp_t;

  logic sclk = 1'b0;
  logic rstn = 1'b0;
  always #5 sclk = ~sclk;

  d2l_tx_scheduler_if #(.DATA_WIDTH(64), .NUM_REQ(2)) if0 ();
  d2l_tx_scheduler_if #(.DATA_WIDTH(64), .NUM_REQ(2)) if1 ();
  d2l_tx_scheduler_if #(.DATA_WIDTH(8),  .NUM_REQ(1)) if2 ();
  logic cs0, a0, b0, busy0, gid0, td0;
  logic cs1, a1, b1, busy1, gid1, td1;
  logic cs2, a2, b2, busy2, gid2, td2;

  d2l_tx_scheduler #(.DATA_WIDTH(64), .NUM_REQ(2), .GAP_CYCLES(2)) u0 (
    .sclk(sclk), .rstn(rstn), .rq(if0.slave), .CS(cs0), .OutLine1(a0), .OutLine0(b0),
    .busy(busy0), .grant_id(gid0), .tx_done(td0));
  d2l_tx_scheduler #(.DATA_WIDTH(64), .NUM_REQ(2), .GAP_CYCLES(0)) u1 (
    .sclk(sclk), .rstn(rstn), .rq(if1.slave), .CS(cs1), .OutLine1(a1), .OutLine0(b1),
    .busy(busy1), .grant_id(gid1), .tx_done(td1));
  d2l_tx_scheduler #(.DATA_WIDTH(8), .NUM_REQ(1), .GAP_CYCLES(2)) u2 (
    .sclk(sclk), .rstn(rstn), .rq(if2.slave), .CS(cs2), .OutLine1(a2), .OutLine0(b2),
    .busy(busy2), .grant_id(gid2), .tx_done(td2));

  int   sel = 0;
  int   total = 0, bad = 0, frames = 0, tx_pulses = 0, cnt = 0, hi = 0;
  logic cs_m, a_m, b_m, td_m, gid_m, busy_m;
  logic [63:0] rx;
  logic [1:0]  pq[$];
  int          hiq[$];
  exp_t        exp_q[$];
  exp_t        e;
  logic        r0_seen = 1'b0;

  always_comb begin
    cs_m   = sel == 0 ? cs0   : sel == 1 ? cs1   : cs2;
    a_m    = sel == 0 ? a0    : sel == 1 ? a1    : a2;
    b_m    = sel == 0 ? b0    : sel == 1 ? b1    : b2;
    td_m   = sel == 0 ? td0   : sel == 1 ? td1   : td2;
    gid_m  = sel == 0 ? gid0  : sel == 1 ? gid1  : gid2;
    busy_m = sel == 0 ? busy0 : sel == 1 ? busy1 : busy2;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic id, input logic [63:0] d);
    exp_t x;
    x.id = id;
    x.data = d;
    exp_q.push_back(x);
  endtask

  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  task automatic wait_frames(input int tgt, input string tag);
    for (int c = 0; c < 500 && frames < tgt; c++) @(negedge sclk);
    chk(tag, 64'(frames >= tgt), 64'd1);
  endtask

  task automatic wait_idle(input string tag);
    for (int c = 0; c < 100 && busy_m; c++) @(negedge sclk);
    chk(tag, 64'(busy_m), 64'd0);
  endtask

  // Receiver model: first CS-low cycle carries no data, then one pair per cycle.
  always @(negedge sclk) begin
    if (!rstn) begin
      cnt = 0;
      hi = 0;
    end else begin
      if (td_m) tx_pulses++;
      if (sel == 1 && if1.req_ready[0]) r0_seen = 1'b1;
      if (!cs_m) begin
        if (cnt == 0) begin
          rx = '0;
          pq.delete();
          hiq.push_back(hi);
        end else begin
          rx = {rx[61:0], a_m, b_m};
          pq.push_back({a_m, b_m});
        end
        cnt++;
      end else if (cnt > 0) begin
        chk("cs_low_len", 64'(cnt), 64'(sel == 2 ? 5 : 33));
        chk("tx_done_at_end", 64'(td_m), 64'd1);
        total++;
        assert (exp_q.size() != 0) else begin
          bad++;
          $error("FAIL sb_empty observed=0 expected=nonzero");
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("rx_word", rx, e.data);
          chk("grant_id", 64'(gid_m), 64'(e.id));
        end
        frames++;
        cnt = 0;
        hi = 1;
      end else hi++;
    end
  end

  initial begin
    int base, tp;
    logic rdy_seen;
    if0.req_valid = '0; if0.req_data = '0;
    if1.req_valid = '0; if1.req_data = '0;
    if2.req_valid = '0; if2.req_data = '0;
    repeat (3) @(negedge sclk);
    chk("rst_cs", 64'(cs0), 64'd1);
    chk("rst_lines", 64'({a0, b0}), 64'd0);
    chk("rst_busy", 64'(busy0), 64'd0);
    chk("rst_ready", 64'(if0.req_ready), 64'd0);
    chk("rst_txdone", 64'(td0), 64'd0);
    chk("rst_gid", 64'(gid0), 64'd0);
    step();
    rstn = 1'b1;
    step();
    // single word from requester 0
    push_exp(1'b0, 64'hA5A5_1234_5678_9ABC);
    if0.req_data[63:0] = 64'hA5A5_1234_5678_9ABC;
    if0.req_valid = 2'b01;
    #1 chk("t1_ready", 64'(if0.req_ready), 64'd1);
    step();
    chk("t1_cs_low", 64'(cs0), 64'd0);
    chk("t1_busy", 64'(busy0), 64'd1);
    chk("t1_ready_off", 64'(if0.req_ready), 64'd0);
    if0.req_valid = 2'b00;
    wait_frames(1, "t1_frame");
    chk("t1_npairs", 64'(pq.size()), 64'd32);
    chk("t1_pairs", 64'({pq[0], pq[1], pq[2], pq[3]}), 64'b10100101);
    chk("t1_txdone_pulses", 64'(tx_pulses), 64'd1);
    wait_idle("t1_idle");
    // two requesters held valid, alternating grants
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    step();
    base = frames;
    if0.req_data = {64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    for (int i = 0; i < 4; i++) push_exp(i[0], i[0] ? 64'h2222_2222_2222_2222 : 64'h1111_1111_1111_1111);
    hiq.delete();
    if0.req_valid = 2'b11;
    wait_frames(base + 3, "t2_three");
    for (int c = 0; c < 20 && cs0; c++) @(negedge sclk);
    if0.req_valid = 2'b00;
    wait_frames(base + 4, "t2_four");
    chk("t2_nstarts", 64'(hiq.size()), 64'd4);
    for (int i = 1; i < 4 && i < hiq.size(); i++) chk("t2_gap", 64'(hiq[i]), 64'd3);
    wait_idle("t2_idle");
    // requester 1 alone, zero gap
    sel = 1;
    base = frames;
    hiq.delete();
    r0_seen = 1'b0;
    for (int i = 0; i < 3; i++) push_exp(1'b1, 64'hDEAD_BEEF_0BAD_F00D);
    if1.req_data[127:64] = 64'hDEAD_BEEF_0BAD_F00D;
    if1.req_valid = 2'b10;
    wait_frames(base + 2, "t3_two");
    for (int c = 0; c < 20 && cs1; c++) @(negedge sclk);
    if1.req_valid = 2'b00;
    wait_frames(base + 3, "t3_three");
    chk("t3_nstarts", 64'(hiq.size()), 64'd3);
    for (int i = 1; i < 3 && i < hiq.size(); i++) chk("t3_gap", 64'(hiq[i]), 64'd1);
    chk("t3_ready0_never", 64'(r0_seen), 64'd0);
    wait_idle("t3_idle");
    // reset mid-frame
    sel = 0;
    base = frames;
    tp = tx_pulses;
    pq.delete();
    if0.req_data[63:0] = 64'hFFFF_0000_FFFF_0000;
    if0.req_valid = 2'b01;
    step();
    if0.req_valid = 2'b00;
    for (int c = 0; c < 40 && pq.size() < 10; c++) @(negedge sclk);
    chk("t4_reached_pair10", 64'(pq.size()), 64'd10);
    #1 rstn = 1'b0;
    #1 chk("t4_cs_async", 64'(cs0), 64'd1);
    chk("t4_busy_async", 64'(busy0), 64'd0);
    step();
    step();
    rstn = 1'b1;
    repeat (40) @(negedge sclk);
    chk("t4_no_done", 64'(frames), 64'(base));
    chk("t4_no_txdone", 64'(tx_pulses), 64'(tp));
    push_exp(1'b0, 64'h0123_4567_89AB_CDEF);
    if0.req_data[63:0] = 64'h0123_4567_89AB_CDEF;
    if0.req_valid = 2'b01;
    step();
    if0.req_valid = 2'b00;
    wait_frames(base + 1, "t4_after");
    wait_idle("t4_idle");
    // request raised mid-frame waits for IDLE
    base = frames;
    push_exp(1'b1, 64'hFEDC_BA98_7654_3210);
    if0.req_data[127:64] = 64'hFEDC_BA98_7654_3210;
    if0.req_valid = 2'b10;
    step();
    if0.req_valid = 2'b00;
    chk("t5_first_cs", 64'(cs0), 64'd0);
    repeat (5) step();
    push_exp(1'b0, 64'h5A5A_0F0F_C3C3_9696);
    if0.req_data[63:0] = 64'h5A5A_0F0F_C3C3_9696;
    if0.req_valid = 2'b01;
    rdy_seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge sclk);
      if (!busy0) break;
      rdy_seen |= |if0.req_ready;
    end
    chk("t5_ready_held_low", 64'(rdy_seen), 64'd0);
    chk("t5_ready_idle", 64'(if0.req_ready), 64'd1);
    step();
    chk("t5_granted", 64'(cs0), 64'd0);
    chk("t5_gid", 64'(gid0), 64'd0);
    if0.req_valid = 2'b00;
    wait_frames(base + 2, "t5_frames");
    wait_idle("t5_idle");
    // 8-bit single-requester instance
    sel = 2;
    base = frames;
    push_exp(1'b0, 64'hC3);
    if2.req_data = 8'hC3;
    if2.req_valid = 1'b1;
    step();
    if2.req_valid = 1'b0;
    wait_frames(base + 1, "t6_frame");
    chk("t6_npairs", 64'(pq.size()), 64'd4);
    chk("t6_pairs", 64'({pq[0], pq[1], pq[2], pq[3]}), 64'b11000011);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
